stall_responder: RTL and testbench
==================================

// Module: stall_responder
// PURPOSE
//  Consumer side of the hazard-stall interface. Takes the combinational STALL from the hazard
//  detector, the EX-stage branch/jump flush and the instruction-memory ready flag.
//  Owns the IF/ID pipeline register; drives PC write-enable and the ID/EX bubble select.
//  Tracks the HALT freeze and, optionally, stall/flush performance counters.
// PARAMETERS
//  INSTR_W   16       instruction and PC width
//  NOP_INSTR 16'h0800 encoding injected into IF/ID on flush or fetch-wait
//  HALT_OP   5'b00000 opcode [15:11] that freezes fetch
//  WDOG_MAX  255      consecutive STALL cycles before err_wdog is asserted (8-bit counter)
//  CNT_W     16       performance-counter width
// PORTS
//  clk         in  1       system clock; all state updates on posedge
//  rst         in  1       synchronous, active-high reset
//  stall_in    in  1       hazard STALL (load-use, or branch/JR RAW), same cycle
//  flush_in    in  1       taken branch/jump resolved; redirect PC, kill IF/ID
//  imem_ready  in  1       instruction memory returned instr_in this cycle
//  instr_in    in  INSTR_W fetched instruction
//  pc2_in      in  INSTR_W PC+2 of the fetched instruction
//  pc_wr_en    out 1       PC register write enable (combinational)
//  idex_bubble out 1       force ID/EX control signals to NOP (combinational)
//  ifid_instr  out INSTR_W IF/ID instruction register
//  ifid_pc2    out INSTR_W IF/ID PC+2 register
//  ifid_valid  out 1       IF/ID holds a real instruction
//  halted      out 1       HALT has entered IF/ID; fetch frozen
//  err_wdog    out 1       sticky: stall_in held for WDOG_MAX consecutive cycles
//  stall_cnt   out CNT_W   stall cycles (perf counter, see CONFIGURATION)
//  flush_cnt   out CNT_W   flush events (perf counter)
// BEHAVIOUR
//  Reset: ifid_instr=NOP_INSTR, ifid_pc2=0, ifid_valid=0, halted=0, err_wdog=0, counters=0.
//  Reset state is RUN. During rst, pc_wr_en=0 and idex_bubble=1.
//  FSM states: RUN, STALL, FWAIT, HALT. Input priority is rst > flush_in > stall_in > !imem_ready.
//  flush_in (any state except HALT): pc_wr_en=1, idex_bubble=1.
//   Next edge: IF/ID loads NOP_INSTR with valid=0. Next state is RUN.
//   The wdog counter is cleared.
//  stall_in (RUN/STALL/FWAIT): pc_wr_en=0, idex_bubble=1. IF/ID holds all three fields.
//   Next state is STALL. The wdog counter increments, saturating at WDOG_MAX.
//   err_wdog sets when the counter reaches WDOG_MAX and clears only on rst.
//  !imem_ready with no stall or flush: pc_wr_en=0, idex_bubble=0.
//   IF/ID loads NOP_INSTR with valid=0. Next state is FWAIT.
//  Otherwise (normal advance): pc_wr_en=1, idex_bubble=0.
//   IF/ID loads {instr_in, pc2_in} with valid=1. Next state is RUN. The wdog counter is cleared.
//  STALL exit is the first cycle stall_in=0; the held IF/ID instruction then advances unchanged.
//   Latency is 1 bubble per stall cycle.
//  HALT entry: when an instruction with [15:11]==HALT_OP is loaded into IF/ID with valid=1,
//   the next state is HALT and halted=1.
//   In HALT: pc_wr_en=0, idex_bubble=0, IF/ID frozen.
//   flush_in in HALT (older branch) exits to RUN with the flush behaviour above;
//   HALT is left only by flush or rst.
//  Simultaneous flush_in and stall_in: flush wins. The held instruction is wrong-path and is killed.
//  Reset mid-stall: all state is cleared on that edge, with no partial IF/ID update.
// CONFIGURATION
//  STALL_PERF_CNT_EN defined: stall_cnt increments on every cycle with stall_in=1
//   and flush_cnt on every flush_in cycle, outside HALT.
//   Both counters wrap modulo 2^CNT_W.
//  STALL_PERF_CNT_EN undefined: no counter flops; stall_cnt and flush_cnt are tied to 0.
// STRUCTURE
//  Shared package/include: state encodings (RUN=2'd0, STALL=2'd1, FWAIT=2'd2, HALT=2'd3),
//   NOP_INSTR and HALT_OP constants.
//  One sub-module, ifid_reg: a DFF bank with hold/load/kill controls.
//   The FSM, wdog and counters stay in the top.
// TESTING
//  Load-use: stall_in=1 for 1 cycle with ifid_instr=16'h4123
//   -> pc_wr_en=0, idex_bubble=1, IF/ID holds 16'h4123, then it advances.
//  Flush while stalled: stall_in=1, flush_in=1 together
//   -> pc_wr_en=1, next ifid_instr=16'h0800, valid=0, state RUN.
//  Fetch wait: imem_ready=0 for 3 cycles -> 3 NOPs, pc_wr_en=0;
//   on ready=1, instr_in=16'hC004 loads with valid=1.
//  HALT: instr_in=16'h0000 advances -> halted=1 next cycle, pc_wr_en=0 held;
//   flush_in=1 -> halted=0, RUN.
//  Watchdog: stall_in held 255 cycles -> err_wdog=1; stays 1 after stall drops; rst clears it.
//  Perf (macro on): 5 stall cycles + 2 flushes -> stall_cnt=5, flush_cnt=2; macro off -> both 0.

Source files
------------

// File: rtl/stall_responder_pkg.sv
// Shared definitions for the stall responder: FSM state encoding and
// default instruction constants (NOP filler and HALT opcode).
package stall_responder_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FWAIT = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

  localparam logic [15:0] NOP_INSTR_DEF = 16'h0800;
  localparam logic [4:0]  HALT_OP_DEF   = 5'b00000;

  // True when the opcode field [15:11] of a 16-bit instruction is the HALT opcode.
  function automatic logic is_halt_op(input logic [15:0] instr, input logic [4:0] op);
    return (instr[15:11] == op);
  endfunction

endpackage

// File: rtl/stall_responder_ifid.sv
// IF/ID pipeline register: instruction, PC+2 and valid flag.
// kill has priority over load; with neither asserted the register holds.
module ifid_reg
  import stall_responder_pkg::*;
#(
  parameter int          W   = 16,
  parameter logic [15:0] NOP = NOP_INSTR_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         kill,
  input  logic [W-1:0] instr_d,
  input  logic [W-1:0] pc2_d,
  output logic [W-1:0] instr,
  output logic [W-1:0] pc2,
  output logic         valid
);

  // Reset / kill / load / hold of the three IF/ID fields.
  always_ff @(posedge clk) begin
    if (rst) begin
      instr <= W'(NOP);
      pc2   <= '0;
      valid <= 1'b0;
    end else if (kill) begin
      instr <= W'(NOP);
      pc2   <= '0;
      valid <= 1'b0;
    end else if (load) begin
      instr <= instr_d;
      pc2   <= pc2_d;
      valid <= 1'b1;
    end
  end

endmodule

// File: rtl/stall_responder.sv
// Hazard-stall consumer: owns IF/ID, drives PC write enable and the ID/EX
// bubble select, tracks the HALT freeze and a stall watchdog.
// Optional perf counters are built when STALL_PERF_CNT_EN is defined;
// otherwise stall_cnt/flush_cnt are tied to zero.
//
// Handshake: imem_ready qualifies instr_in/pc2_in in the same cycle; a fetch
// is consumed (IF/ID loads, PC advances) only on a cycle with imem_ready=1
// and no flush, stall or HALT. pc_wr_en and idex_bubble are combinational.
module stall_responder
  import stall_responder_pkg::*;
#(
  parameter int                 INSTR_W   = 16,
  parameter logic [INSTR_W-1:0] NOP_INSTR = NOP_INSTR_DEF,
  parameter logic [4:0]         HALT_OP   = HALT_OP_DEF,
  parameter int                 WDOG_MAX  = 255,
  parameter int                 CNT_W     = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall_in,
  input  logic               flush_in,
  input  logic               imem_ready,
  input  logic [INSTR_W-1:0] instr_in,
  input  logic [INSTR_W-1:0] pc2_in,
  output logic               pc_wr_en,
  output logic               idex_bubble,
  output logic [INSTR_W-1:0] ifid_instr,
  output logic [INSTR_W-1:0] ifid_pc2,
  output logic               ifid_valid,
  output logic               halted,
  output logic               err_wdog,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic [CNT_W-1:0]   flush_cnt
);

  localparam logic [7:0] WDOG_LIM = 8'(WDOG_MAX);

  state_t     state, state_nxt;
  logic       ifid_load, ifid_kill;
  logic       wdog_inc;
  logic [7:0] wdog_cnt, wdog_nxt;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_RUN;
    else     state <= state_nxt;
  end

  // Next state and control outputs; priority rst > flush > HALT freeze > stall > fetch wait.
  // The watchdog counts only stall cycles that actually hold the pipe;
  // every other cycle breaks the run and clears it.
  always_comb begin
    pc_wr_en    = 1'b0;
    idex_bubble = 1'b0;
    ifid_load   = 1'b0;
    ifid_kill   = 1'b0;
    wdog_inc    = 1'b0;
    state_nxt   = state;
    if (rst) begin
      idex_bubble = 1'b1;
      state_nxt   = ST_RUN;
    end else if (flush_in) begin
      pc_wr_en    = 1'b1;
      idex_bubble = 1'b1;
      ifid_kill   = 1'b1;
      state_nxt   = ST_RUN;
    end else if (state == ST_HALT) begin
      state_nxt   = ST_HALT;
    end else if (stall_in) begin
      idex_bubble = 1'b1;
      wdog_inc    = 1'b1;
      state_nxt   = ST_STALL;
    end else if (!imem_ready) begin
      ifid_kill   = 1'b1;
      state_nxt   = ST_FWAIT;
    end else begin
      pc_wr_en    = 1'b1;
      ifid_load   = 1'b1;
      state_nxt   = is_halt_op(16'(instr_in), HALT_OP) ? ST_HALT : ST_RUN;
    end
  end

  assign halted = (state == ST_HALT);

  // Saturating watchdog count value for the next edge.
  always_comb begin
    wdog_nxt = 8'd0;
    if (wdog_inc) wdog_nxt = (wdog_cnt == WDOG_LIM) ? wdog_cnt : wdog_cnt + 8'd1;
  end

  // Watchdog counter and sticky error; error sets on the edge the count reaches the limit.
  always_ff @(posedge clk) begin
    if (rst) begin
      wdog_cnt <= 8'd0;
      err_wdog <= 1'b0;
    end else begin
      wdog_cnt <= wdog_nxt;
      if (wdog_inc && wdog_nxt == WDOG_LIM) err_wdog <= 1'b1;
    end
  end

  ifid_reg #(
    .W   (INSTR_W),
    .NOP (16'(NOP_INSTR))
  ) u_ifid (
    .clk     (clk),
    .rst     (rst),
    .load    (ifid_load),
    .kill    (ifid_kill),
    .instr_d (instr_in),
    .pc2_d   (pc2_in),
    .instr   (ifid_instr),
    .pc2     (ifid_pc2),
    .valid   (ifid_valid)
  );

`ifdef STALL_PERF_CNT_EN
  logic [CNT_W-1:0] stall_q, flush_q;

  // Perf counters: stall and flush input cycles outside HALT, wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else if (state != ST_HALT) begin
      if (stall_in) stall_q <= stall_q + 1'b1;
      if (flush_in) flush_q <= flush_q + 1'b1;
    end
  end

  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_stall_responder.sv
// Self-checking bench for stall_responder: directed scenarios followed by
// randomized traffic, all compared against a behavioural model of the
// pipeline-control rules.
module tb_stall_responder;

  logic        clk = 1'b0;
  logic        rst, stall_in, flush_in, imem_ready;
  logic [15:0] instr_in, pc2_in;
  logic        pc_wr_en, idex_bubble, ifid_valid, halted, err_wdog;
  logic [15:0] ifid_instr, ifid_pc2, stall_cnt, flush_cnt;

  int passed = 0;
  int total  = 0;

  // Behavioural model state
  logic [15:0] m_instr, m_pc2;
  logic        m_valid, m_halted, m_err;
  int          m_run;          // consecutive effective stall cycles
  logic [15:0] m_sc, m_fc;

  // clock / reset block
  always #5 clk = ~clk;

  stall_responder dut (
    .clk(clk), .rst(rst), .stall_in(stall_in), .flush_in(flush_in),
    .imem_ready(imem_ready), .instr_in(instr_in), .pc2_in(pc2_in),
    .pc_wr_en(pc_wr_en), .idex_bubble(idex_bubble), .ifid_instr(ifid_instr),
    .ifid_pc2(ifid_pc2), .ifid_valid(ifid_valid), .halted(halted),
    .err_wdog(err_wdog), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_instr = 16'h0800; m_pc2 = 16'h0; m_valid = 1'b0; m_halted = 1'b0;
    m_err = 1'b0; m_run = 0; m_sc = 16'h0; m_fc = 16'h0;
  endtask

  // One clock cycle: drive inputs, check combinational outputs, clock, check registers.
  task automatic step(input logic r, input logic s, input logic f, input logic rdy,
                      input logic [15:0] ins, input logic [15:0] p2);
    logic e_pw, e_bb;
    rst = r; stall_in = s; flush_in = f; imem_ready = rdy; instr_in = ins; pc2_in = p2;
    #2;
    if (r)             begin e_pw = 1'b0; e_bb = 1'b1; end
    else if (f)        begin e_pw = 1'b1; e_bb = 1'b1; end
    else if (m_halted) begin e_pw = 1'b0; e_bb = 1'b0; end
    else if (s)        begin e_pw = 1'b0; e_bb = 1'b1; end
    else if (!rdy)     begin e_pw = 1'b0; e_bb = 1'b0; end
    else               begin e_pw = 1'b1; e_bb = 1'b0; end
    chk("pc_wr_en", 32'(pc_wr_en), 32'(e_pw));
    chk("idex_bubble", 32'(idex_bubble), 32'(e_bb));
    @(posedge clk);
    if (r) model_reset();
    else begin
`ifdef STALL_PERF_CNT_EN
      if (!m_halted) begin
        if (s) m_sc = m_sc + 16'd1;
        if (f) m_fc = m_fc + 16'd1;
      end
`endif
      if (f) begin
        m_instr = 16'h0800; m_pc2 = 16'h0; m_valid = 1'b0; m_halted = 1'b0; m_run = 0;
      end else if (m_halted) begin
        m_run = 0;
      end else if (s) begin
        if (m_run < 255) m_run++;
        if (m_run == 255) m_err = 1'b1;
      end else if (!rdy) begin
        m_instr = 16'h0800; m_pc2 = 16'h0; m_valid = 1'b0; m_run = 0;
      end else begin
        m_instr = ins; m_pc2 = p2; m_valid = 1'b1; m_run = 0;
        m_halted = (ins[15:11] == 5'b00000);
      end
    end
    #1;
    chk("ifid_instr", 32'(ifid_instr), 32'(m_instr));
    chk("ifid_valid", 32'(ifid_valid), 32'(m_valid));
    if (m_valid) chk("ifid_pc2", 32'(ifid_pc2), 32'(m_pc2));
    chk("halted", 32'(halted), 32'(m_halted));
    chk("err_wdog", 32'(err_wdog), 32'(m_err));
    chk("stall_cnt", 32'(stall_cnt), 32'(m_sc));
    chk("flush_cnt", 32'(flush_cnt), 32'(m_fc));
  endtask

  initial begin
    logic [15:0] ri;
    rst = 1'b1; stall_in = 1'b0; flush_in = 1'b0; imem_ready = 1'b1;
    instr_in = 16'h0; pc2_in = 16'h0;
    model_reset();
    @(posedge clk); #1;

    // Reset state
    step(1, 0, 0, 1, 16'h1111, 16'h0002);
    chk("rst_instr", 32'(ifid_instr), 32'h0800);
    chk("rst_valid", 32'(ifid_valid), 32'h0);

    // Load-use stall
    step(0, 0, 0, 1, 16'h4123, 16'h0010);
    step(0, 1, 0, 1, 16'h5555, 16'h0012);
    chk("loaduse_hold", 32'(ifid_instr), 32'h4123);
    step(0, 0, 0, 1, 16'h4567, 16'h0012);
    chk("loaduse_adv", 32'(ifid_instr), 32'h4567);

    // Flush while stalled
    step(0, 1, 0, 1, 16'h6000, 16'h0014);
    step(0, 1, 1, 1, 16'h6000, 16'h0014);
    chk("flush_kill", 32'(ifid_instr), 32'h0800);

    // Fetch wait x3, then ready
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 16'hDEAD, 16'h0020);
    step(0, 0, 0, 1, 16'hC004, 16'h0022);
    chk("fwait_load", 32'(ifid_instr), 32'hC004);

    // HALT then flush out
    step(0, 0, 0, 1, 16'h0000, 16'h0024);
    chk("halt_set", 32'(halted), 32'h1);
    for (int i = 0; i < 3; i++) step(0, i == 1, 0, 1, 16'h7777, 16'h0026);
    step(0, 0, 1, 1, 16'h7777, 16'h0026);
    chk("halt_exit", 32'(halted), 32'h0);

    // Watchdog
    for (int i = 0; i < 254; i++) step(0, 1, 0, 1, 16'h4000, 16'h0030);
    chk("wdog_254", 32'(err_wdog), 32'h0);
    step(0, 1, 0, 1, 16'h4000, 16'h0030);
    chk("wdog_255", 32'(err_wdog), 32'h1);
    step(0, 0, 0, 1, 16'h4001, 16'h0032);
    chk("wdog_sticky", 32'(err_wdog), 32'h1);
    step(1, 0, 0, 1, 16'h4001, 16'h0032);
    chk("wdog_rst", 32'(err_wdog), 32'h0);

    // Perf counters: 5 stalls + 2 flushes
    for (int i = 0; i < 5; i++) step(0, 1, 0, 1, 16'h4800, 16'h0040);
    for (int i = 0; i < 2; i++) step(0, 0, 1, 1, 16'h4800, 16'h0040);
`ifdef STALL_PERF_CNT_EN
    chk("perf_stall", 32'(stall_cnt), 32'd5);
    chk("perf_flush", 32'(flush_cnt), 32'd2);
`else
    chk("perf_stall_off", 32'(stall_cnt), 32'd0);
    chk("perf_flush_off", 32'(flush_cnt), 32'd0);
`endif

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      ri = 16'($urandom);
      step($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 25,
           $urandom_range(0, 99) < 10, $urandom_range(0, 99) >= 20,
           ri, 16'($urandom));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
